// File: rtl/aes_round_key_stream.sv
// AES-128 key scheduler: expands a cipher key into 11 round keys (one per clock),
// then streams them ascending (encrypt) or descending (decrypt) over valid/ready.
module aes_round_key_stream #(
    parameter int unsigned NR = 10
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         i_Start,
    input  logic [127:0] i_Key,
    input  logic         i_fEncrypt,
    input  logic         i_Ready,
    output logic         o_Valid,
    output logic [127:0] o_Key,
    output logic [3:0]   o_Round,
    output logic         o_Busy,
    output logic         o_Done
);

    localparam int unsigned KW   = 128;
    localparam logic [3:0]  LAST = 4'(NR);

    // Byte b of the S-box lives at bits [8*(255-b)+7 -: 8], i.e. base {~b, 3'b111}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM, DONE} state_t;

    state_t        state, state_next;
    logic [KW-1:0] store [NR+1];
    logic [3:0]    cnt;
    logic          enc;
    logic [KW-1:0] prev_key, key_next;
    logic [31:0]   temp, n0, n1, n2, n3;
    logic          xfer, last_beat;
    logic [3:0]    ptr_next;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One AES-128 expansion step from the previously written round key.
    always_comb begin
        prev_key = store[cnt - 4'd1];
        temp     = {sub_byte(prev_key[23:16]), sub_byte(prev_key[15:8]),
                    sub_byte(prev_key[7:0]),   sub_byte(prev_key[31:24])}
                   ^ {rcon(cnt), 24'h000000};
        n0       = prev_key[127:96] ^ temp;
        n1       = prev_key[95:64]  ^ n0;
        n2       = prev_key[63:32]  ^ n1;
        n3       = prev_key[31:0]   ^ n2;
        key_next = {n0, n1, n2, n3};
    end

    assign xfer      = (state == STREAM) && o_Valid && i_Ready;
    assign last_beat = xfer && (enc ? (o_Round == LAST) : (o_Round == 4'd0));
    assign ptr_next  = enc ? (o_Round + 4'd1) : (o_Round - 4'd1);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_Start)       state_next = EXPAND;
            EXPAND:  if (cnt == LAST)   state_next = STREAM;
            STREAM:  if (last_beat)     state_next = DONE;
            DONE:                       state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Key store, mode, counters and registered stream outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            store   <= '{default: '0};
            cnt     <= 4'd0;
            enc     <= 1'b0;
            o_Valid <= 1'b0;
            o_Key   <= '0;
            o_Round <= 4'd0;
            o_Busy  <= 1'b0;
            o_Done  <= 1'b0;
        end else begin
            o_Valid <= (state_next == STREAM);
            o_Busy  <= (state_next != IDLE);
            o_Done  <= (state_next == DONE);
            case (state)
                IDLE: if (i_Start) begin
                    store[0] <= i_Key;
                    enc      <= i_fEncrypt;
                    cnt      <= 4'd1;
                end
                EXPAND: begin
                    store[cnt] <= key_next;
                    cnt        <= cnt + 4'd1;
                    // Decrypt's first beat is the key being written this edge, so bypass it.
                    if (cnt == LAST) begin
                        o_Round <= enc ? 4'd0 : LAST;
                        o_Key   <= enc ? store[0] : key_next;
                    end
                end
                STREAM: if (xfer && !last_beat) begin
                    o_Round <= ptr_next;
                    o_Key   <= store[ptr_next];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_round_key_stream.md
Name: aes_round_key_stream

Overview:
- Sequential key scheduler. It expands a 128-bit cipher key into all 11 AES-128 round keys, one round per clock, and holds them in an internal key store.
- It then streams the keys to the round datapath over a valid/ready handshake.
- Encrypt mode streams round 0..10. Decrypt mode streams round 10..0, which is the reverse-direction feed the decryption datapath needs.
- It replaces per-round combinational KeyExpansion calls with a single pre-computed, flow-controlled key source.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst  input  1  asynchronous, active-low reset.
- i_Start  input  1  one-cycle request to begin a schedule; honoured only in IDLE.
- i_Key  input  128  cipher key, byte 0 in bits [127:120]; sampled with i_Start.
- i_fEncrypt  input  1  1 = stream ascending 0..10, 0 = stream descending 10..0; sampled with i_Start.
- i_Ready  input  1  consumer ready for the current key beat.
- o_Valid  output  1  o_Key/o_Round hold a valid beat.
- o_Key  output  128  round key for the current beat.
- o_Round  output  4  round index of o_Key (0..10).
- o_Busy  output  1  high in every state except IDLE.
- o_Done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; o_Valid, o_Busy and o_Done are 0; o_Key = 0; o_Round = 0; key store is cleared; mode bit is 0.
- State IDLE:
  - If i_Start=1 at a rising edge: store[0] <= i_Key, latch i_fEncrypt, expansion counter r <= 1, go to EXPAND.
  - Otherwise stay in IDLE.
- State EXPAND: at each edge, store[r] <= f(store[r-1], Rcon[r]) and r <= r+1.
  - f = standard AES-128 step: RotWord, then SubWord (internal S-box), then XOR with Rcon, applied to word 3; cascading XOR into words 0..3.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 in the top byte.
  - After the edge that writes store[10], go to STREAM. EXPAND therefore lasts exactly 10 cycles.
- State STREAM:
  - Beat pointer starts at 0 (encrypt) or 10 (decrypt).
  - o_Valid=1, o_Key=store[ptr], o_Round=ptr.
  - A beat transfers on an edge where o_Valid && i_Ready.
  - After a transfer the pointer moves +1 (encrypt) or -1 (decrypt).
  - While o_Valid && !i_Ready, o_Key and o_Round are held stable, and o_Valid must not drop.
  - Transfer of round 10 (encrypt) or round 0 (decrypt) ends the stream: next state DONE, o_Valid <= 0.
  - i_Ready held high gives one beat per cycle, 11 consecutive beats.
- State DONE: o_Done=1 for exactly one cycle, o_Busy=1; then go to IDLE.
- Latency: i_Start accepted at edge T0 → o_Valid first high in the cycle after edge T10 (11 edges). With i_Ready constantly high, o_Done is high in the cycle after the edge that accepts the 11th beat.
- i_Start outside IDLE is ignored. There is no queuing, and the in-flight schedule and mode are unchanged.
- i_Key and i_fEncrypt changes outside the i_Start cycle have no effect.
- o_Key is registered; it is not combinational from i_Key.
- o_Busy is low in IDLE only, and is high in the same cycle as o_Done.
- Reset asserted mid-EXPAND or mid-STREAM aborts immediately to the reset values. No o_Done is generated. After release, a fresh i_Start is required.
- i_Start in the IDLE cycle directly following DONE is honoured normally.

Test Plan:
- Encrypt, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, i_Ready=1 → o_Valid rises 11 edges after i_Start. Beats must be: round 0 = input key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. o_Round must be 0..10 consecutively, and o_Done must pulse once.
- Decrypt, key 5468617473206D79204B756E67204675 → first beat round 10 = 28FDDEF86DA4244ACCC0A4FE3B316F26. Then round 2 = 56082007C71AB18F76435569A03AF7FA, round 1 = E232FCF191129188B159E4E6D679A293, last beat round 0 = input key.
- Backpressure: i_Ready toggled pseudo-randomly, including 5-cycle low stretches → o_Key/o_Round stable and o_Valid high while stalled. Exactly 11 transfers with no skipped or duplicated round.
- i_Start pulsed with a different key and mode during EXPAND and during STREAM → ignored; the original key sequence completes unchanged.
- Rst asserted asynchronously mid-STREAM (between clock edges) → outputs zero immediately with no o_Done. A new i_Start after release produces a correct full schedule.
- Back-to-back: i_Start in the first IDLE cycle after o_Done → second schedule starts with correct latency and values.
